// File: rtl/icache_arb_pkg.sv
// rtl/icache_arb_pkg.sv - shared constants and types for the icache debug-port arbiter
package icache_arb_pkg;

    localparam int ADDR_W_DEF = 30;
    localparam int DATA_W_DEF = 32;

    localparam logic REQ_LOADER  = 1'b0;
    localparam logic REQ_MONITOR = 1'b1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCK0    = 2'd1,
        LOCK1    = 2'd2
    } lock_state_t;

endpackage

// File: rtl/icache_debug_arbiter_rr_arb2.sv
// rtl/icache_debug_arbiter_rr_arb2.sv - two-way round-robin grant with eligibility mask
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    output logic [1:0] gnt,
    output logic       win
);

    logic       last;
    logic [1:0] elig;

    assign elig = req & mask;

    // On a tie the requester that was not served last wins; grants are held off during reset.
    always_comb begin
        gnt = 2'b00;
        win = 1'b0;
        if (!rst && (elig != 2'b00)) begin
            win = (elig == 2'b11) ? ~last : elig[1];
            gnt = win ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (gnt != 2'b00) begin
            last <= win;
        end
    end

endmodule

// File: rtl/icache_debug_arbiter.sv
// rtl/icache_debug_arbiter.sv - shares the icache debug port between loader and monitor
// Optional grant locking is enabled by defining ICACHE_ARB_LOCK_EN.
module icache_debug_arbiter
    import icache_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
`ifdef ICACHE_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_we,
    input  logic [DATA_W-1:0] dbg_rdata
);

    logic [1:0] gnt;
    logic [1:0] mask;
    logic       win;
    logic       any_gnt;
    logic       win_we;
    logic       rd_pend;
    logic       rd_owner;

    rr_arb2 u_rr_arb2 (
        .clk  (clk),
        .rst  (rst),
        .req  ({req1, req0}),
        .mask (mask),
        .gnt  (gnt),
        .win  (win)
    );

    assign gnt0    = gnt[0];
    assign gnt1    = gnt[1];
    assign any_gnt = gnt0 | gnt1;
    assign win_we  = (win == REQ_MONITOR) ? we1 : we0;

    always_comb begin
        dbg_addr  = '0;
        dbg_wdata = '0;
        dbg_we    = 1'b0;
        if (any_gnt) begin
            dbg_addr  = (win == REQ_MONITOR) ? addr1 : addr0;
            dbg_wdata = (win == REQ_MONITOR) ? wdata1 : wdata0;
            dbg_we    = win_we;
        end
    end

    // The cache registers debug reads, so the response lands one cycle after the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            rd_owner <= REQ_LOADER;
        end else begin
            rd_pend <= any_gnt & ~win_we;
            if (any_gnt & ~win_we) begin
                rd_owner <= win;
            end
        end
    end

    assign rvalid0 = rd_pend & (rd_owner == REQ_LOADER);
    assign rvalid1 = rd_pend & (rd_owner == REQ_MONITOR);
    assign rdata   = rd_pend ? dbg_rdata : '0;

`ifdef ICACHE_ARB_LOCK_EN
    lock_state_t state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= UNLOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    // Mask depends only on the registered state to keep the grant path loop-free.
    assign mask = (state == LOCK0) ? 2'b01 :
                  (state == LOCK1) ? 2'b10 : 2'b11;

    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED: begin
                if (gnt0 && lock0) begin
                    state_nxt = LOCK0;
                end else if (gnt1 && lock1) begin
                    state_nxt = LOCK1;
                end
            end
            LOCK0: begin
                if (!req0 || (gnt0 && !lock0)) begin
                    state_nxt = UNLOCKED;
                end
            end
            LOCK1: begin
                if (!req1 || (gnt1 && !lock1)) begin
                    state_nxt = UNLOCKED;
                end
            end
            default: state_nxt = UNLOCKED;
        endcase
    end
`else
    assign mask = 2'b11;
`endif

endmodule

// File: tb/tb_icache_debug_arbiter.sv
// tb/tb_icache_debug_arbiter.sv - scoreboard bench for icache_debug_arbiter (ICACHE_ARB_LOCK_EN optional)
module tb_icache_debug_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic        lock0 = 1'b0, lock1 = 1'b0;
    logic [29:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, dbg_we;
    logic [31:0] rdata, dbg_wdata;
    logic [29:0] dbg_addr;
    logic [31:0] dbg_rdata = '0;

    always #5 clk = ~clk;

    icache_debug_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
`ifdef ICACHE_ARB_LOCK_EN
        .lock0     (lock0),
        .lock1     (lock1),
`endif
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_we    (dbg_we),
        .dbg_rdata (dbg_rdata)
    );

    // Cache debug port: 4K words, out-of-range writes dropped and reads return 0.
    logic [31:0] cmem [0:4095];
    always @(posedge clk) begin
        if (dbg_we && dbg_addr[29:12] == 18'd0) cmem[dbg_addr[11:0]] <= dbg_wdata;
        dbg_rdata <= (dbg_addr[29:12] == 18'd0) ? cmem[dbg_addr[11:0]] : 32'd0;
    end

    typedef struct {
        logic        owner;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb [$];
    logic [31:0] ref_mem [0:4095];
    logic        mlast = 1'b1;
    int          mstate = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic rs,
                       input logic r0, input logic w0, input logic [29:0] a0, input logic [31:0] d0, input logic l0,
                       input logic r1, input logic w1, input logic [29:0] a1, input logic [31:0] d1, input logic l1);
        rsp_t        e;
        logic        e0, e1, mg, mw, mwe;
        logic [29:0] ma;
        logic [31:0] md;
        @(negedge clk);
        rst = rs; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
        #1;
        if (rs) begin
            sb.delete();
            mlast  = 1'b1;
            mstate = 0;
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rvalid0", {31'd0, rvalid0}, {31'd0, ~e.owner});
            check("rvalid1", {31'd0, rvalid1}, {31'd0, e.owner});
            check("rdata", rdata, e.data);
        end else begin
            check("rvalid0_idle", {31'd0, rvalid0}, 32'd0);
            check("rvalid1_idle", {31'd0, rvalid1}, 32'd0);
            check("rdata_idle", rdata, 32'd0);
        end
        e0  = !rs && r0 && (mstate != 2);
        e1  = !rs && r1 && (mstate != 1);
        mw  = (e0 && e1) ? ~mlast : e1;
        mg  = e0 || e1;
        ma  = mg ? (mw ? a1 : a0) : 30'd0;
        md  = mg ? (mw ? d1 : d0) : 32'd0;
        mwe = mg && (mw ? w1 : w0);
        check("gnt0", {31'd0, gnt0}, {31'd0, mg && !mw});
        check("gnt1", {31'd0, gnt1}, {31'd0, mg && mw});
        check("dbg_addr", {2'd0, dbg_addr}, {2'd0, ma});
        check("dbg_wdata", dbg_wdata, md);
        check("dbg_we", {31'd0, dbg_we}, {31'd0, mwe});
        if (mg) begin
            if (mwe) begin
                if (ma[29:12] == 18'd0) ref_mem[ma[11:0]] = md;
            end else begin
                e.owner = mw;
                e.data  = (ma[29:12] == 18'd0) ? ref_mem[ma[11:0]] : 32'd0;
                sb.push_back(e);
            end
            mlast = mw;
        end
`ifdef ICACHE_ARB_LOCK_EN
        if (!rs) begin
            case (mstate)
                0: if (mg && !mw && l0) mstate = 1;
                   else if (mg && mw && l1) mstate = 2;
                1: if (!r0 || (mg && !mw && !l0)) mstate = 0;
                default: if (!r1 || (mg && mw && !l1)) mstate = 0;
            endcase
        end
`endif
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            cmem[i]    = 32'd0;
            ref_mem[i] = 32'd0;
        end
        cyc(1'b1, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 30'h10, 32'd0, 1'b0, 1'b1, 1'b1, 30'h20, 32'h1, 1'b0);
        // Loader write, monitor read-back of the same word.
        cyc(1'b0, 1'b1, 1'b1, 30'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 1'b1, 1'b0, 30'h10, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 1'b1, 1'b1, 30'h20, 32'h12345678, 1'b0);
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 1'b1, 1'b0, 30'h20, 32'd0, 1'b0, 1'b1, 1'b0, 30'h10, 32'd0, 1'b0);
        // Out-of-range word address: write dropped, read returns 0.
        cyc(1'b0, 1'b1, 1'b1, 30'h1000, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 30'h1000, 32'd0, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0);
        idle();
        // Reset with a read pending, then first tie after reset.
        cyc(1'b0, 1'b1, 1'b0, 30'h10, 32'd0, 1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 30'h10, 32'd0, 1'b0, 1'b1, 1'b0, 30'h20, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 30'h10, 32'd0, 1'b0, 1'b1, 1'b0, 30'h20, 32'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 1'b1, 1'b0, 30'h20, 32'd0, 1'b0);
        // Locked burst of three loader writes while the monitor keeps asking.
        cyc(1'b0, 1'b1, 1'b1, 30'h30, 32'hA1, 1'b1, 1'b1, 1'b0, 30'h10, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 30'h31, 32'hA2, 1'b1, 1'b1, 1'b0, 30'h10, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 30'h32, 32'hA3, 1'b0, 1'b1, 1'b0, 30'h10, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 30'h30, 32'd0, 1'b0, 1'b1, 1'b0, 30'h31, 32'd0, 1'b0);
        // Mixed traffic with random requests, directions and lock bits.
        for (int i = 0; i < 40; i++)
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 30'($urandom_range(0, 63)),
                $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 30'($urandom_range(0, 63)),
                $urandom, 1'($urandom_range(0, 1)));
        idle();
        idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
